// File: rtl/brick_state.sv
// Brick wall tracker for a breakout game: keeps the 3x5 brick field, scans one
// brick per cycle against the latched ball position, and reports the first hit.
module brick_state #(
  parameter int BALL_SIZE = 8,
  parameter int BRICK_W   = 124,
  parameter int BRICK_H   = 20,
  parameter int COL_PITCH = 128,
  parameter int ROW_PITCH = 24,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  output logic [14:0] alive,
  output logic        hit_valid,
  output logic [3:0]  hit_index,
  output logic        hit_side,
  output logic [7:0]  score,
  output logic        level_clear,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state, state_next;
  logic [3:0]  idx, idx_next;
  logic [9:0]  bx_ball, by_ball;
  logic [1:0]  row;
  logic [2:0]  col;
  logic [10:0] brick_x, brick_y;
  logic [10:0] ball_l, ball_r, ball_t, ball_b, centre_x;
  logic        overlap, side, hit;
  logic [8:0]  score_sum;
  logic [7:0]  score_next;

  // All geometry is done at 11 bits so ball + size can never wrap.
  always_comb begin
    row = 2'd0;
    if (idx >= 4'd10)
      row = 2'd2;
    else if (idx >= 4'd5)
      row = 2'd1;
    col      = 3'(idx - 4'(row) * 4'd5);
    brick_x  = 11'(ORIGIN_X) + 11'(col) * 11'(COL_PITCH);
    brick_y  = 11'(ORIGIN_Y) + 11'(row) * 11'(ROW_PITCH);
    ball_l   = {1'b0, bx_ball};
    ball_t   = {1'b0, by_ball};
    ball_r   = ball_l + 11'(BALL_SIZE);
    ball_b   = ball_t + 11'(BALL_SIZE);
    centre_x = ball_l + 11'(BALL_SIZE / 2);
    overlap  = (ball_l < brick_x + 11'(BRICK_W)) && (ball_r > brick_x) &&
               (ball_t < brick_y + 11'(BRICK_H)) && (ball_b > brick_y);
    side     = !((centre_x >= brick_x) && (centre_x <= brick_x + 11'(BRICK_W - 1)));
    hit      = (state == SCAN) && alive[idx] && overlap;
  end

  // Top row is worth the most; the sum carries into bit 8 to detect saturation.
  always_comb begin
    score_sum  = {1'b0, score} + 9'(2'd3 - row);
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (frame_tick && !restart) begin
          state_next = SCAN;
          idx_next   = 4'd0;
        end
      end
      SCAN: begin
        if (hit || idx == 4'd14)
          state_next = IDLE;
        else
          idx_next = idx + 4'd1;
      end
      default: state_next = IDLE;
    endcase
    if (restart)
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alive       <= 15'h7FFF;
      score       <= 8'd0;
      hit_valid   <= 1'b0;
      hit_index   <= 4'd0;
      hit_side    <= 1'b0;
      level_clear <= 1'b0;
      bx_ball     <= 10'd0;
      by_ball     <= 10'd0;
    end else begin
      hit_valid   <= 1'b0;
      level_clear <= (alive == 15'd0);
      if (restart) begin
        alive <= 15'h7FFF;
      end else begin
        if (state == IDLE && frame_tick) begin
          bx_ball <= ball_x;
          by_ball <= ball_y;
        end
        if (hit) begin
          alive[idx] <= 1'b0;
          hit_valid  <= 1'b1;
          hit_index  <= idx;
          hit_side   <= side;
          score      <= score_next;
        end
      end
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: tb/tb_brick_state.sv
// Directed bench for brick_state: a default-size instance plus a BALL_SIZE=4
// instance used for the gap-miss case.
module tb_brick_state;

  logic        clk = 1'b0;
  logic        rst, frame_tick, frame_tick4, restart;
  logic [9:0]  ball_x, ball_y;

  logic [14:0] alive, alive4;
  logic        hit_valid, hit_side, level_clear, busy;
  logic        hit_valid4, hit_side4, level_clear4, busy4;
  logic [3:0]  hit_index, hit_index4;
  logic [7:0]  score, score4;

  int tests = 0;
  int failures = 0;
  int exp_score;
  int busy_cnt;
  bit seen;

  brick_state dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
    .ball_x(ball_x), .ball_y(ball_y), .alive(alive), .hit_valid(hit_valid),
    .hit_index(hit_index), .hit_side(hit_side), .score(score),
    .level_clear(level_clear), .busy(busy)
  );

  brick_state #(.BALL_SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick4), .restart(restart),
    .ball_x(ball_x), .ball_y(ball_y), .alive(alive4), .hit_valid(hit_valid4),
    .hit_index(hit_index4), .hit_side(hit_side4), .score(score4),
    .level_clear(level_clear4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic ft, input logic rs);
    ball_x     = x;
    ball_y     = y;
    frame_tick = ft;
    restart    = rs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitHit(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step();
      if (hit_valid === 1'b1) got = 1'b1;
    end
    checkOutput("hit_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    frame_tick4 = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_alive", 32'(alive), 32'h7FFF);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_hit_valid", 32'(hit_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_level_clear", 32'(level_clear), 32'd0);
    checkOutput("rst_hit_index", 32'(hit_index), 32'd0);
    checkOutput("rst_alive4", 32'(alive4), 32'h7FFF);
    rst = 1'b0;
    step();

    // gap between brick 0 and brick 1 with a 4-pixel ball: full miss scan
    applyStimulus(10'd124, 10'd0, 1'b0, 1'b0);
    frame_tick4 = 1'b1;
    step();
    frame_tick4 = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy4 === 1'b1) busy_cnt++;
      if (hit_valid4 === 1'b1) seen = 1'b1;
      step();
    end
    checkOutput("miss_busy_cycles", 32'(busy_cnt), 32'd15);
    checkOutput("miss_no_hit", 32'(seen), 32'd0);
    checkOutput("miss_alive4", 32'(alive4), 32'h7FFF);

    // brick 0 hit, exact latency; ball moved mid-scan must not matter
    applyStimulus(10'd60, 10'd10, 1'b1, 1'b0);
    step();
    applyStimulus(10'd900, 10'd500, 1'b0, 1'b0);
    checkOutput("b0_t1_hit_valid", 32'(hit_valid), 32'd0);
    checkOutput("b0_t1_busy", 32'(busy), 32'd1);
    step();
    checkOutput("b0_t2_hit_valid", 32'(hit_valid), 32'd1);
    checkOutput("b0_hit_index", 32'(hit_index), 32'd0);
    checkOutput("b0_hit_side", 32'(hit_side), 32'd0);
    checkOutput("b0_alive", 32'(alive), 32'h7FFE);
    checkOutput("b0_score", 32'(score), 32'd3);
    step();
    checkOutput("b0_t3_hit_valid", 32'(hit_valid), 32'd0);
    checkOutput("b0_t3_busy", 32'(busy), 32'd0);
    checkOutput("b0_t3_hold_index", 32'(hit_index), 32'd0);

    // ball straddling bricks 5 and 6: side hits, one per scan
    applyStimulus(10'd122, 10'd30, 1'b1, 1'b0);
    step();
    applyStimulus(10'd122, 10'd30, 1'b0, 1'b0);
    waitHit(20);
    checkOutput("b5_hit_index", 32'(hit_index), 32'd5);
    checkOutput("b5_hit_side", 32'(hit_side), 32'd1);
    checkOutput("b5_score", 32'(score), 32'd5);
    checkOutput("b5_alive", 32'(alive), 32'h7FDE);
    applyStimulus(10'd122, 10'd30, 1'b1, 1'b0);
    step();
    applyStimulus(10'd122, 10'd30, 1'b0, 1'b0);
    waitHit(20);
    checkOutput("b6_hit_index", 32'(hit_index), 32'd6);
    checkOutput("b6_hit_side", 32'(hit_side), 32'd1);
    checkOutput("b6_score", 32'(score), 32'd7);
    checkOutput("b6_alive", 32'(alive), 32'h7F9E);

    // restart mid-scan aimed at brick 10 suppresses the hit
    applyStimulus(10'd60, 10'd54, 1'b1, 1'b0);
    step();
    applyStimulus(10'd60, 10'd54, 1'b0, 1'b0);
    step();
    step();
    step();
    step();
    applyStimulus(10'd60, 10'd54, 1'b0, 1'b1);
    checkOutput("rs_t5_busy", 32'(busy), 32'd1);
    step();
    applyStimulus(10'd60, 10'd54, 1'b0, 1'b0);
    checkOutput("rs_t6_busy", 32'(busy), 32'd0);
    checkOutput("rs_t6_alive", 32'(alive), 32'h7FFF);
    checkOutput("rs_t6_hit_valid", 32'(hit_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (hit_valid === 1'b1) seen = 1'b1;
    end
    checkOutput("rs_no_hit", 32'(seen), 32'd0);
    checkOutput("rs_score", 32'(score), 32'd7);

    // restart wins over a simultaneous frame_tick
    applyStimulus(10'd60, 10'd10, 1'b1, 1'b1);
    step();
    applyStimulus(10'd60, 10'd10, 1'b0, 1'b0);
    checkOutput("rs_ft_busy", 32'(busy), 32'd0);
    step();
    checkOutput("rs_ft_no_hit", 32'(hit_valid), 32'd0);
    checkOutput("rs_ft_alive", 32'(alive), 32'h7FFF);

    // nine full levels; 30 points each, score saturates during level 9
    exp_score = 7;
    for (int lvl = 1; lvl <= 9; lvl++) begin
      for (int k = 0; k < 15; k++) begin
        applyStimulus(10'((k % 5) * 128 + 60), 10'((k / 5) * 24 + 6), 1'b1, 1'b0);
        step();
        frame_tick = 1'b0;
        waitHit(20);
        checkOutput("lvl_hit_index", 32'(hit_index), 32'(k));
        exp_score = exp_score + 3 - (k / 5);
        if (exp_score > 255) exp_score = 255;
      end
      checkOutput("lvl_alive_zero", 32'(alive), 32'd0);
      checkOutput("lvl_clear_early", 32'(level_clear), 32'd0);
      step();
      checkOutput("lvl_clear", 32'(level_clear), 32'd1);
      checkOutput("lvl_score", 32'(score), 32'(exp_score));
      applyStimulus(10'd0, 10'd0, 1'b0, 1'b1);
      step();
      applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
      checkOutput("lvl_reload", 32'(alive), 32'h7FFF);
      step();
      checkOutput("lvl_clear_drop", 32'(level_clear), 32'd0);
    end
    checkOutput("final_score_sat", 32'(score), 32'd255);

    // reset mid-scan beats everything
    applyStimulus(10'd60, 10'd54, 1'b1, 1'b0);
    step();
    frame_tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_score", 32'(score), 32'd0);
    checkOutput("midrst_alive", 32'(alive), 32'h7FFF);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
